// File: rtl/timer_pkg.sv
// Shared constants for the timer control core: TCR/TSR bit positions and
// the clock-select encoding.
package timer_pkg;

    // TCR bit positions
    localparam int unsigned TCR_CKS_LSB = 0;
    localparam int unsigned TCR_OVFIE   = 2;
    localparam int unsigned TCR_UDFIE   = 3;
    localparam int unsigned TCR_EN      = 4;
    localparam int unsigned TCR_DOWN    = 5;
    localparam int unsigned TCR_LOAD    = 7;

    // Number of TCR bits that are actually stored ([5:0])
    localparam int unsigned TCR_STORED_W = 6;

    // TSR bit positions
    localparam int unsigned TSR_OVF  = 0;
    localparam int unsigned TSR_UNDF = 1;

    // Clock-select encoding
    typedef enum logic [1:0] {
        CKS_DIV0 = 2'b00,
        CKS_DIV1 = 2'b01,
        CKS_DIV2 = 2'b10,
        CKS_DIV3 = 2'b11
    } cks_e;

    // Prescaler counter width; at least one bit even when DIV3 == 1
    function automatic int unsigned presc_width(input int unsigned div3);
        return (div3 > 1) ? $clog2(div3) : 1;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running power-of-two prescaler. The counter is log2(DIV3) bits wide;
// a tick is raised when the low log2(DIVsel) bits are all ones, giving one
// tick every DIVsel cycles, the first one DIVsel cycles after a restart.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned DIV0 = 2,
    parameter int unsigned DIV1 = 4,
    parameter int unsigned DIV2 = 8,
    parameter int unsigned DIV3 = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] CKS,
    input  logic       restart,
    output logic       tick
);

    localparam int unsigned PW = presc_width(DIV3);

    // DIV-1 is an all-ones mask of log2(DIV) bits since every DIV is a power of two
    localparam logic [PW-1:0] MASK0 = PW'(DIV0 - 1);
    localparam logic [PW-1:0] MASK1 = PW'(DIV1 - 1);
    localparam logic [PW-1:0] MASK2 = PW'(DIV2 - 1);
    localparam logic [PW-1:0] MASK3 = PW'(DIV3 - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] mask;

    // Select the tick mask for the active divide ratio
    always_comb begin
        mask = MASK0;
        case (cks_e'(CKS))
            CKS_DIV0: mask = MASK0;
            CKS_DIV1: mask = MASK1;
            CKS_DIV2: mask = MASK2;
            CKS_DIV3: mask = MASK3;
            default:  mask = MASK0;
        endcase
    end

    // Next prescaler count: cleared on restart, held at zero while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = cnt_q + PW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Prescaler count register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = EN & ((cnt_q & mask) == mask);

endmodule

// File: rtl/timer_ctrl_core.sv
// Timer control core: TCR storage, prescaler, WIDTH-bit up/down counter
// with reload, sticky OVF/UNDF flags with write-1-to-clear, and maskable IRQ.
module timer_ctrl_core
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV0  = 2,
    parameter int unsigned DIV1  = 4,
    parameter int unsigned DIV2  = 8,
    parameter int unsigned DIV3  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TCR_WR_IN,
    input  logic [7:0]       TCR_IN,
    input  logic [WIDTH-1:0] TDR_IN,
    input  logic [1:0]       TSR_CLR_IN,
    output logic [WIDTH-1:0] TCNT_OUT,
    output logic [1:0]       TSR_OUT,
    output logic [7:0]       TCR_OUT,
    output logic [1:0]       CLK_SEL_OUT,
    output logic             TICK_OUT,
    output logic             IRQ_OUT
);

    logic [TCR_STORED_W-1:0] tcr_q;
    logic [TCR_STORED_W-1:0] tcr_d;
    logic [WIDTH-1:0]        tcnt_q;
    logic [WIDTH-1:0]        tcnt_d;
    logic [1:0]              tsr_q;
    logic [1:0]              tsr_d;
    logic [1:0]              tsr_set;

    logic load;
    logic presc_restart;
    logic tick;
    logic tcr_rsvd_unused;

    // Reserved TCR bit is accepted on the bus but never stored
    assign tcr_rsvd_unused = TCR_IN[6];

    assign load = TCR_WR_IN & TCR_IN[TCR_LOAD];

    // Control register update and prescaler restart detection
    always_comb begin
        tcr_d         = tcr_q;
        presc_restart = load;
        if (TCR_WR_IN) begin
            tcr_d = TCR_IN[TCR_STORED_W-1:0];
            if ((TCR_IN[TCR_CKS_LSB +: 2] != tcr_q[TCR_CKS_LSB +: 2]) ||
                (TCR_IN[TCR_EN] != tcr_q[TCR_EN])) begin
                presc_restart = 1'b1;
            end
        end
    end

    timer_prescaler #(
        .DIV0 (DIV0),
        .DIV1 (DIV1),
        .DIV2 (DIV2),
        .DIV3 (DIV3)
    ) u_prescaler (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (tcr_q[TCR_EN]),
        .CKS     (tcr_q[TCR_CKS_LSB +: 2]),
        .restart (presc_restart),
        .tick    (tick)
    );

    // Counter step / reload and flag update; a LOAD swallows a same-cycle tick,
    // and a flag set outranks a same-cycle clear of that flag
    always_comb begin
        tcnt_d  = tcnt_q;
        tsr_set = '0;
        if (load) begin
            tcnt_d = TDR_IN;
        end else if (tick) begin
            if (tcr_q[TCR_DOWN]) begin
                if (tcnt_q == '0) begin
                    tcnt_d            = '1;
                    tsr_set[TSR_UNDF] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - WIDTH'(1);
                end
            end else begin
                if (tcnt_q == '1) begin
                    tcnt_d           = '0;
                    tsr_set[TSR_OVF] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + WIDTH'(1);
                end
            end
        end
        tsr_d = (tsr_q & ~TSR_CLR_IN) | tsr_set;
    end

    // Control, count and status registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcr_q  <= '0;
            tcnt_q <= '0;
            tsr_q  <= '0;
        end else begin
            tcr_q  <= tcr_d;
            tcnt_q <= tcnt_d;
            tsr_q  <= tsr_d;
        end
    end

    assign TCNT_OUT    = tcnt_q;
    assign TSR_OUT     = tsr_q;
    assign TCR_OUT     = {2'b00, tcr_q};
    assign CLK_SEL_OUT = tcr_q[TCR_CKS_LSB +: 2];
    assign TICK_OUT    = tick;
    assign IRQ_OUT     = (tsr_q[TSR_OVF]  & tcr_q[TCR_OVFIE]) |
                         (tsr_q[TSR_UNDF] & tcr_q[TCR_UDFIE]);

endmodule

// File: tb/tb_timer_ctrl_core.sv
// Bench for timer_ctrl_core: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_timer_ctrl_core;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV0  = 2;
    localparam int unsigned DIV1  = 4;
    localparam int unsigned DIV2  = 8;
    localparam int unsigned DIV3  = 16;
    localparam int unsigned MAXV  = (1 << WIDTH) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             TCR_WR_IN = 1'b0;
    logic [7:0]       TCR_IN = '0;
    logic [WIDTH-1:0] TDR_IN = '0;
    logic [1:0]       TSR_CLR_IN = '0;
    logic [WIDTH-1:0] TCNT_OUT;
    logic [1:0]       TSR_OUT;
    logic [7:0]       TCR_OUT;
    logic [1:0]       CLK_SEL_OUT;
    logic             TICK_OUT;
    logic             IRQ_OUT;

    timer_ctrl_core #(
        .WIDTH (WIDTH),
        .DIV0  (DIV0),
        .DIV1  (DIV1),
        .DIV2  (DIV2),
        .DIV3  (DIV3)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .TCR_WR_IN   (TCR_WR_IN),
        .TCR_IN      (TCR_IN),
        .TDR_IN      (TDR_IN),
        .TSR_CLR_IN  (TSR_CLR_IN),
        .TCNT_OUT    (TCNT_OUT),
        .TSR_OUT     (TSR_OUT),
        .TCR_OUT     (TCR_OUT),
        .CLK_SEL_OUT (CLK_SEL_OUT),
        .TICK_OUT    (TICK_OUT),
        .IRQ_OUT     (IRQ_OUT)
    );

    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Abstract state: stored control bits, count as an integer, flags, and
    // the number of enabled cycles since the last prescaler restart.
    logic [5:0]  m_tcr   = '0;
    int unsigned m_cnt   = 0;
    logic [1:0]  m_tsr   = '0;
    int unsigned m_phase = 0;

    bit          mt_tick;
    bit          mt_load;
    bit          mt_restart;
    logic [1:0]  mt_set;

    function automatic int unsigned div_of(input logic [1:0] c);
        case (c)
            2'd0:    return DIV0;
            2'd1:    return DIV1;
            2'd2:    return DIV2;
            default: return DIV3;
        endcase
    endfunction

    function automatic logic exp_tick();
        int unsigned d;
        d = div_of(m_tcr[1:0]);
        return m_tcr[4] && ((m_phase % d) == d - 1);
    endfunction

    // Model state update at each clock edge, asynchronous reset
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_tcr   = '0;
            m_cnt   = 0;
            m_tsr   = '0;
            m_phase = 0;
        end else begin
            mt_tick    = exp_tick();
            mt_load    = TCR_WR_IN && TCR_IN[7];
            mt_restart = mt_load || (TCR_WR_IN &&
                         ((TCR_IN[1:0] != m_tcr[1:0]) || (TCR_IN[4] != m_tcr[4])));
            mt_set = '0;
            if (mt_load) begin
                m_cnt = TDR_IN;
            end else if (mt_tick) begin
                if (m_tcr[5]) begin
                    if (m_cnt == 0) begin m_cnt = MAXV; mt_set[1] = 1'b1; end
                    else m_cnt = m_cnt - 1;
                end else begin
                    if (m_cnt == MAXV) begin m_cnt = 0; mt_set[0] = 1'b1; end
                    else m_cnt = m_cnt + 1;
                end
            end
            m_tsr = (m_tsr & ~TSR_CLR_IN) | mt_set;
            if (mt_restart)    m_phase = 0;
            else if (m_tcr[4]) m_phase = m_phase + 1;
            else               m_phase = 0;
            if (TCR_WR_IN) m_tcr = TCR_IN[5:0];
        end
    end

    // Compare every DUT output with the model on the falling edge
    always @(negedge CLK) begin
        chk("tcnt", TCNT_OUT, m_cnt);
        chk("tsr", TSR_OUT, m_tsr);
        chk("tcr", TCR_OUT, {2'b00, m_tcr});
        chk("clk_sel", CLK_SEL_OUT, m_tcr[1:0]);
        chk("tick", TICK_OUT, exp_tick());
        chk("irq", IRQ_OUT, (m_tsr[0] & m_tcr[2]) | (m_tsr[1] & m_tcr[3]));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wr_tcr(input logic [7:0] v, input logic [WIDTH-1:0] tdr);
        TCR_IN    = v;
        TDR_IN    = tdr;
        TCR_WR_IN = 1'b1;
        step();
        TCR_WR_IN = 1'b0;
        TCR_IN    = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tcnt"}, TCNT_OUT, 0);
        chk({tag, "_tsr"}, TSR_OUT, 0);
        chk({tag, "_tcr"}, TCR_OUT, 0);
        chk({tag, "_clksel"}, CLK_SEL_OUT, 0);
        chk({tag, "_tick"}, TICK_OUT, 0);
        chk({tag, "_irq"}, IRQ_OUT, 0);
    endtask

    initial begin
        step();
        step();
        chk_all_zero("reset");
        RST = 1'b0;
        step();

        // Up count at DIV0: tick every 2nd cycle, count 5 ten cycles after write
        wr_tcr(8'h10, '0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("tick_div2", TICK_OUT, (i % 2) == 1);
        end
        chk("tcnt_10cyc", TCNT_OUT, 5);

        // LOAD 0xFE, then FF, then wrap to 00 with OVF
        wr_tcr(8'h90, 8'hFE);
        chk("load_fe", TCNT_OUT, 8'hFE);
        step(); step();
        chk("up_ff", TCNT_OUT, 8'hFF);
        step(); step();
        chk("wrap_00", TCNT_OUT, 8'h00);
        chk("ovf_set", TSR_OUT, 2'b01);
        chk("irq_masked", IRQ_OUT, 0);
        wr_tcr(8'h14, '0);
        chk("irq_ovfie", IRQ_OUT, 1);

        // Clear OVF, then down count at DIV3 from 1
        TSR_CLR_IN = 2'b01;
        step();
        TSR_CLR_IN = 2'b00;
        chk("ovf_clr", TSR_OUT, 0);
        wr_tcr(8'hB3, 8'h01);
        chk("load_01", TCNT_OUT, 8'h01);
        chk("tcr_b3", TCR_OUT, 8'h33);
        repeat (16) step();
        chk("down_00", TCNT_OUT, 8'h00);
        chk("no_udf_yet", TSR_OUT, 0);
        repeat (16) step();
        chk("down_ff", TCNT_OUT, 8'hFF);
        chk("udf_set", TSR_OUT, 2'b10);
        wr_tcr(8'h3B, '0);
        chk("irq_udfie", IRQ_OUT, 1);
        TSR_CLR_IN = 2'b10;
        step();
        TSR_CLR_IN = 2'b00;
        chk("udf_clr", TSR_OUT, 0);
        chk("irq_drop", IRQ_OUT, 0);

        // Overflow tick with a same-cycle OVF clear: set wins
        wr_tcr(8'h94, 8'hFF);
        step();
        TSR_CLR_IN = 2'b01;
        step();
        TSR_CLR_IN = 2'b00;
        chk("ovf_set_wins", TSR_OUT, 2'b01);
        chk("ovf_wrap", TCNT_OUT, 0);

        // LOAD on a tick edge: tick dropped, no increment, no flag
        TSR_CLR_IN = 2'b01;
        step();
        TSR_CLR_IN = 2'b00;
        chk("clr_again", TSR_OUT, 0);
        wr_tcr(8'h90, 8'hFF);
        chk("load_ff", TCNT_OUT, 8'hFF);
        step();
        chk("tick_before_load", TICK_OUT, 1);
        wr_tcr(8'h90, 8'h42);
        chk("load_beats_tick", TCNT_OUT, 8'h42);
        chk("load_no_flag", TSR_OUT, 0);

        // CKS 00 -> 11 mid-period: first tick 16 cycles after the write
        step(); step();
        chk("pre_cks_tcnt", TCNT_OUT, 8'h43);
        wr_tcr(8'h13, '0);
        chk("cks_sel", CLK_SEL_OUT, 2'b11);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("tick_div16", TICK_OUT, i == 15);
        end
        chk("cks_tcnt", TCNT_OUT, 8'h44);

        // EN=0 holds the count and suppresses ticks
        wr_tcr(8'h03, '0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("dis_tick", TICK_OUT, 0);
        end
        chk("dis_hold", TCNT_OUT, 8'h44);

        // Asynchronous reset mid-count
        wr_tcr(8'h10, '0);
        step(); step(); step();
        chk("pre_rst_tcnt", TCNT_OUT, 8'h45);
        RST = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step();
        RST = 1'b0;

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            TCR_WR_IN = ($urandom_range(0, 7) == 0);
            TCR_IN    = 8'($urandom);
            TCR_IN[4] = ($urandom_range(0, 5) != 0);
            TCR_IN[7] = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0:       TDR_IN = '0;
                1:       TDR_IN = WIDTH'(1);
                2:       TDR_IN = '1;
                3:       TDR_IN = WIDTH'(MAXV - 1);
                default: TDR_IN = WIDTH'($urandom);
            endcase
            TSR_CLR_IN = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            RST        = ($urandom_range(0, 499) == 0);
            step();
        end
        TCR_WR_IN  = 1'b0;
        TSR_CLR_IN = '0;
        RST        = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
